// File: rtl/bram_arb_pkg.sv
// Shared definitions for the two-requester word-to-byte BRAM arbiter.
package bram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; last_grant only advances on an accepted grant.
module rr_arb2
    import bram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic       grant_valid,
    output logic       grant_id
);

    logic last_grant;

    always_comb begin
        grant_valid = en && (req != 2'b00);
        grant_id    = REQ_I;
        if (req[REQ_I] && req[REQ_D]) begin
            grant_id = ~last_grant;
        end else if (req[REQ_D]) begin
            grant_id = REQ_D;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= REQ_I;
        end else if (grant_valid) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/bram_word_arbiter.sv
// Shares a byte-wide single-port BRAM between a 32-bit fetch port and a 32-bit load/store port,
// splitting each word access into four byte slots and assembling reads little-endian.
module bram_word_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [7:0]        bram_dina,
    input  logic [7:0]        bram_douta,
    output logic              busy
);

    localparam int unsigned WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q;
    logic [WCW-1:0]      wcnt_q;
    logic                gnt_q;
    logic [ADDR_W-3:0]   word_q;
    logic                we_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;
    logic                slot_rd;
    logic                grant_valid;
    logic                grant_id;

    // Read-slot tracking pipeline: marks which byte lane douta carries RD_LAT cycles later.
    logic [RD_LAT-1:0]   pv_q;
    logic [1:0]          pidx_q [RD_LAT];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    rr_arb2 u_arb (
        .clk         (clka),
        .rst         (rsta),
        .en          (state_q == IDLE),
        .req         ({d_req, i_req}),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        bram_ena   = 1'b0;
        bram_wea   = 1'b0;
        bram_addra = '0;
        bram_dina  = '0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        slot_rd    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) state_d = ISSUE;
            end
            ISSUE: begin
                if (we_q) begin
                    bram_ena = be_q[cnt_q];
                    bram_wea = be_q[cnt_q];
                end else begin
                    bram_ena = 1'b1;
                    slot_rd  = 1'b1;
                end
                // Address and data stay quiet on disabled write slots.
                if (bram_ena) begin
                    bram_addra = {word_q, cnt_q};
                    if (we_q) bram_dina = wdata_q[8*cnt_q +: 8];
                end
                if (cnt_q == 2'd3) state_d = we_q ? DONE : WAIT;
            end
            WAIT: begin
                if (wcnt_q == WCW'(RD_LAT - 1)) state_d = DONE;
            end
            DONE: begin
                i_done  = (gnt_q == REQ_I);
                d_done  = (gnt_q == REQ_D);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            gnt_q   <= REQ_I;
            word_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
            pv_q    <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) pidx_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && grant_valid) begin
                gnt_q  <= grant_id;
                cnt_q  <= '0;
                wcnt_q <= '0;
                if (grant_id == REQ_D) begin
                    word_q  <= d_addr[ADDR_W-1:2];
                    we_q    <= d_we;
                    be_q    <= d_be;
                    wdata_q <= d_wdata;
                end else begin
                    word_q  <= i_addr[ADDR_W-1:2];
                    we_q    <= 1'b0;
                    be_q    <= '0;
                    wdata_q <= '0;
                end
            end
            if (state_q == ISSUE) cnt_q <= cnt_q + 2'd1;
            if (state_q == WAIT) wcnt_q <= wcnt_q + WCW'(1);

            pv_q[0]   <= slot_rd;
            pidx_q[0] <= cnt_q;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pv_q[i]   <= pv_q[i-1];
                pidx_q[i] <= pidx_q[i-1];
            end
            if (pv_q[RD_LAT-1]) begin
                if (gnt_q == REQ_I) i_rdata[8*pidx_q[RD_LAT-1] +: 8] <= bram_douta;
                else                d_rdata[8*pidx_q[RD_LAT-1] +: 8] <= bram_douta;
            end
        end
    end

endmodule

// File: tb/tb_bram_word_arbiter.sv
// Scoreboard bench for bram_word_arbiter with a behavioural byte-wide BRAM (read latency 1).
module tb_bram_word_arbiter;

    logic        clka = 1'b0;
    logic        rsta = 1'b1;
    logic        i_req = 1'b0;
    logic [12:0] i_addr = '0;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [12:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        bram_ena;
    logic        bram_wea;
    logic [12:0] bram_addra;
    logic [7:0]  bram_dina;
    logic [7:0]  bram_douta = '0;
    logic        busy;

    bram_word_arbiter #(.ADDR_W(13), .RD_LAT(1)) dut (
        .clka       (clka),
        .rsta       (rsta),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_done     (i_done),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_be       (d_be),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_done     (d_done),
        .d_rdata    (d_rdata),
        .bram_ena   (bram_ena),
        .bram_wea   (bram_wea),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .bram_douta (bram_douta),
        .busy       (busy)
    );

    always #5 clka = ~clka;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural BRAM, read-first, one cycle read latency; logs every write.
    typedef struct { int c; int a; int d; } wr_t;
    bit [7:0] mem [8192];
    wr_t      wlog [$];
    int       cyc = 0;

    always @(posedge clka) begin
        wr_t w;
        cyc = cyc + 1;
        if (bram_ena) begin
            if (bram_wea) begin
                mem[bram_addra] <= bram_dina;
                w.c = cyc;
                w.a = int'(bram_addra);
                w.d = int'(bram_dina);
                wlog.push_back(w);
            end
            bram_douta <= mem[bram_addra];
        end
    end

    typedef struct {
        bit          port;
        bit          we;
        int          base;
        logic [31:0] wdata;
        logic [31:0] data;
        int          lat;
        int          nena;
    } exp_t;
    exp_t q [$];

    // Monitor: tracks each transaction from busy rising and scores it on the done pulse.
    bit bprev = 1'b0;
    int start = 0;
    int nena = 0;
    int viol = 0;

    always @(negedge clka) begin
        exp_t e;
        int   slot;
        if (rsta) begin
            bprev = 1'b0;
        end else begin
            if (busy && !bprev) begin
                start = cyc;
                nena  = 0;
                viol  = 0;
            end
            if (bram_ena) begin
                nena++;
                if (q.size() > 0) begin
                    slot = cyc - start;
                    if (slot < 0 || slot > 3) begin
                        viol++;
                    end else begin
                        if (int'(bram_addra) != q[0].base + slot) viol++;
                        if (bram_wea !== q[0].we) viol++;
                        if (bram_wea && bram_dina !== q[0].wdata[8*slot +: 8]) viol++;
                    end
                end
            end
            if (i_done || d_done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual i_done=%0b d_done=%0b required none",
                             i_done, d_done);
                end else begin
                    e = q.pop_front();
                    chk("done_port", {31'd0, d_done}, {31'd0, e.port});
                    chk("done_onehot", {31'd0, i_done & d_done}, 32'd0);
                    chk("latency", cyc - start + 2, e.lat);
                    chk("ena_cycles", nena, e.nena);
                    chk("bram_seq_violations", viol, 0);
                    if (!e.we) chk("rdata", e.port ? d_rdata : i_rdata, e.data);
                end
            end
            bprev = busy;
        end
    end

    task automatic wait_done(input bit port);
        int n = 0;
        while (n < 60 && !(port ? d_done : i_done)) begin
            @(negedge clka);
            n++;
        end
        if (n == 60) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual no done on port %0d required done", port);
        end
    endtask

    function automatic exp_t mk(input bit port, input bit we, input int addr,
                                input logic [31:0] wd, input logic [31:0] rd, input int ne);
        exp_t e;
        e.port  = port;
        e.we    = we;
        e.base  = addr & ~3;
        e.wdata = wd;
        e.data  = rd;
        e.lat   = we ? 6 : 7;
        e.nena  = ne;
        return e;
    endfunction

    task automatic d_txn(input bit we, input logic [3:0] be, input int addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int ne);
        @(negedge clka);
        q.push_back(mk(1'b1, we, addr, wd, rd, ne));
        d_we    = we;
        d_be    = be;
        d_addr  = addr[12:0];
        d_wdata = wd;
        d_req   = 1'b1;
        wait_done(1'b1);
        d_req = 1'b0;
    endtask

    task automatic i_txn(input int addr, input logic [31:0] rd);
        @(negedge clka);
        q.push_back(mk(1'b0, 1'b0, addr, 32'd0, rd, 4));
        i_addr = addr[12:0];
        i_req  = 1'b1;
        wait_done(1'b0);
        i_req = 1'b0;
    endtask

    // Packed byte lists: addresses, data and slot offsets of the expected write log.
    task automatic chk_writes(input int n, input logic [31:0] addrs, input logic [31:0] datas,
                              input logic [31:0] slots);
        chk("wr_count", wlog.size(), n);
        for (int k = 0; k < n && k < wlog.size(); k++) begin
            chk("wr_addr", wlog[k].a, {24'd0, addrs[8*k +: 8]});
            chk("wr_data", wlog[k].d, {24'd0, datas[8*k +: 8]});
            chk("wr_slot", wlog[k].c - wlog[0].c, {24'd0, slots[8*k +: 8]});
        end
        wlog.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_ena"}, {31'd0, bram_ena}, 32'd0);
        chk({tag, "_wea"}, {31'd0, bram_wea}, 32'd0);
        chk({tag, "_addra"}, {19'd0, bram_addra}, 32'd0);
        chk({tag, "_dina"}, {24'd0, bram_dina}, 32'd0);
        chk({tag, "_done"}, {30'd0, i_done, d_done}, 32'd0);
        chk({tag, "_i_rdata"}, i_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clka);
        chk_zero("reset");
        rsta = 1'b0;

        d_txn(1'b1, 4'b1111, 0, 32'h3322_11AA, 32'd0, 4);
        chk_writes(4, 32'h0302_0100, 32'h3322_11AA, 32'h0302_0100);

        d_txn(1'b0, 4'b0000, 0, 32'd0, 32'h3322_11AA, 4);

        d_txn(1'b1, 4'b0101, 4, 32'hDDCC_BBAA, 32'd0, 2);
        chk_writes(2, 32'h0000_0604, 32'h0000_CCAA, 32'h0000_0200);
        d_txn(1'b0, 4'b0000, 4, 32'd0, 32'h00CC_00AA, 4);

        i_txn(7, 32'h00CC_00AA);

        d_txn(1'b1, 4'b0000, 0, 32'hFFFF_FFFF, 32'd0, 0);
        chk_writes(0, 32'd0, 32'd0, 32'd0);

        // Reset lands during the third byte slot of a write to word 8.
        @(negedge clka);
        d_we    = 1'b1;
        d_be    = 4'b1111;
        d_addr  = 13'd8;
        d_wdata = 32'h4433_2211;
        d_req   = 1'b1;
        repeat (3) @(posedge clka);
        @(negedge clka);
        chk("pre_reset_addra", {19'd0, bram_addra}, 32'd10);
        rsta  = 1'b1;
        #1;
        chk_zero("abort");
        d_req = 1'b0;
        @(negedge clka);
        rsta = 1'b0;
        chk("mem8", {24'd0, mem[8]}, 32'h11);
        chk("mem9", {24'd0, mem[9]}, 32'h22);
        chk("mem10", {24'd0, mem[10]}, 32'h00);
        chk("mem11", {24'd0, mem[11]}, 32'h00);
        chk_writes(2, 32'h0000_0908, 32'h0000_2211, 32'h0000_0100);

        // Both ports held from reset: grants alternate D, I, D, I.
        @(negedge clka);
        q.push_back(mk(1'b1, 1'b0, 0, 32'd0, 32'h3322_11AA, 4));
        q.push_back(mk(1'b0, 1'b0, 0, 32'd0, 32'h3322_11AA, 4));
        q.push_back(mk(1'b1, 1'b0, 0, 32'd0, 32'h3322_11AA, 4));
        q.push_back(mk(1'b0, 1'b0, 0, 32'd0, 32'h3322_11AA, 4));
        d_we   = 1'b0;
        d_addr = 13'd0;
        i_addr = 13'd0;
        d_req  = 1'b1;
        i_req  = 1'b1;
        fork
            begin
                wait_done(1'b1);
                @(negedge clka);
                wait_done(1'b1);
                d_req = 1'b0;
            end
            begin
                wait_done(1'b0);
                @(negedge clka);
                wait_done(1'b0);
                i_req = 1'b0;
            end
        join

        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(negedge clka);
            n++;
        end
        chk("queue_drained", q.size(), 0);
        repeat (3) @(negedge clka);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
